// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int AES128_NR   = 10;
    localparam int AES192_NR   = 12;
    localparam int AES256_NR   = 14;
    localparam int ROUND_IDX_W = 4;

endpackage

// File: rtl/aes_stage_cnt.sv
// Modulo-STAGE_LAT counter; wrap marks the last stage cycle of a round.
module aes_stage_cnt #(
    parameter int STAGE_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] cnt,
    output logic       wrap
);

    localparam logic [3:0] CNT_LAST = 4'(STAGE_LAT - 1);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign wrap = en && (cnt == CNT_LAST);

endmodule

// File: rtl/aes_round_sched.sv
// Control sequencer for an iterative AES encryption datapath:
// load, NR rounds of fixed-latency stages, then hold the result until taken.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int NR        = 10,
    parameter int STAGE_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic       dp_load,
    output logic       dp_en,
    output logic       round_step,
    output logic [3:0] round_idx,
    output logic       last_round,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    if (!(NR == AES128_NR || NR == AES192_NR || NR == AES256_NR)) begin : g_bad_nr
        $error("aes_round_sched: NR must be 10, 12 or 14");
    end
    if (STAGE_LAT < 1 || STAGE_LAT > 15) begin : g_bad_lat
        $error("aes_round_sched: STAGE_LAT must be in 1..15");
    end

    localparam logic [ROUND_IDX_W-1:0] NR_L       = ROUND_IDX_W'(NR);
    localparam logic [3:0]             STAGE_LAST = 4'(STAGE_LAT - 1);

    state_e                  state_q, state_d;
    logic [ROUND_IDX_W-1:0]  round_idx_q, round_idx_d;
    logic [3:0]              stage_cnt;
    logic                    stage_wrap;
    logic                    in_round;

    assign in_round = (state_q == ROUND);

    aes_stage_cnt #(
        .STAGE_LAT (STAGE_LAT)
    ) u_stage_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_round || abort),
        .en    (in_round),
        .cnt   (stage_cnt),
        .wrap  (stage_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
        end
    end

    // NOTE: hold-by-default assignments first, so no path through the case leaves a latch.
    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                if (abort) begin
                    state_d     = IDLE;
                    round_idx_d = '0;
                end else begin
                    state_d     = ROUND;
                    round_idx_d = ROUND_IDX_W'(1);
                end
            end
            ROUND: begin
                if (abort) begin
                    state_d     = IDLE;
                    round_idx_d = '0;
                end else if (stage_wrap) begin
                    if (round_idx_q == NR_L) begin
                        state_d = DONE;
                    end else begin
                        round_idx_d = round_idx_q + ROUND_IDX_W'(1);
                    end
                end
            end
            DONE: begin
                // The offered result stays up until it is taken or the block is cancelled.
                if (out_ready || abort) begin
                    state_d     = IDLE;
                    round_idx_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                round_idx_d = '0;
            end
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign dp_load    = (state_q == INIT);
    assign dp_en      = in_round;
    assign round_step = in_round && (stage_cnt == STAGE_LAST);
    assign round_idx  = round_idx_q;
    // Only meaningful while the round stages run; round_idx also sits at NR in DONE.
    assign last_round = in_round && (round_idx_q == NR_L);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: default instance plus an NR=14/STAGE_LAT=1 instance.
module tb_aes_round_sched;

    localparam int NR  = 10;
    localparam int LAT = 2;
    localparam logic [10:0] IDLE_V = {7'b1000000, 4'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       abort     = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, dp_load, dp_en, round_step, last_round, out_valid, busy;
    logic [3:0] round_idx;

    logic       in_valid2  = 1'b0;
    logic       abort2     = 1'b0;
    logic       out_ready2 = 1'b1;
    logic       in_ready2, dp_load2, dp_en2, round_step2, last_round2, out_valid2, busy2;
    logic [3:0] round_idx2;

    aes_round_sched #(.NR(NR), .STAGE_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .abort(abort),
        .dp_load(dp_load), .dp_en(dp_en), .round_step(round_step), .round_idx(round_idx),
        .last_round(last_round), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    aes_round_sched #(.NR(14), .STAGE_LAT(1)) dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .abort(abort2),
        .dp_load(dp_load2), .dp_en(dp_en2), .round_step(round_step2), .round_idx(round_idx2),
        .last_round(last_round2), .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;
    int exp_q[$];
    logic ov_prev = 1'b0;

    // Scoreboard: each accept predicts the cycle out_valid first rises.
    always @(negedge clk) begin
        int e;
        if (!rst_n) begin
            exp_q.delete();
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL sb_unexpected: out_valid rose at cycle %0d with no block pending", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e) begin
                        mismatched++;
                        $display("FAIL sb_latency: out_valid rose at cycle %0d, expected cycle %0d", cyc, e);
                    end
                end
            end
            if (abort && busy) exp_q.delete();
            if (in_valid && in_ready && !abort) exp_q.push_back(cyc + 2 + NR * LAT);
            ov_prev = out_valid;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] obs();
        return {in_ready, dp_load, dp_en, round_step, last_round, out_valid, busy, round_idx};
    endfunction

    function automatic logic [10:0] obs2();
        return {in_ready2, dp_load2, dp_en2, round_step2, last_round2, out_valid2, busy2, round_idx2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        compared++;
        if (obs() !== IDLE_V) begin
            mismatched++;
            $display("FAIL reset_state: got %b want %b", obs(), IDLE_V);
        end
        compared++;
        if (obs2() !== IDLE_V) begin
            mismatched++;
            $display("FAIL reset_state_nr14: got %b want %b", obs2(), IDLE_V);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_block();
        logic [10:0] exp_v;
        logic [3:0]  ei;
        int          steps;
        steps = 0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        @(negedge clk);
        compared++;
        if (obs() !== IDLE_V) begin
            mismatched++;
            $display("FAIL single_accept: got %b want %b", obs(), IDLE_V);
        end
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k == 1) in_valid = 1'b0;
            @(negedge clk);
            ei = (k >= 2 && k <= 21) ? 4'((k - 2) / 2 + 1) : (k == 22) ? 4'd10 : 4'd0;
            exp_v = {k >= 23, k == 1, (k >= 2 && k <= 21), (k >= 2 && k <= 21 && k % 2 == 1),
                     (k == 20 || k == 21), k == 22, (k >= 1 && k <= 22), ei};
            if (round_step) steps++;
            compared++;
            if (obs() !== exp_v) begin
                mismatched++;
                $display("FAIL single_T+%0d: got %b want %b", k, obs(), exp_v);
            end
        end
        compared++;
        if (steps !== NR) begin
            mismatched++;
            $display("FAIL single_steps: got %0d round_step pulses want %0d", steps, NR);
        end
    endtask

    task automatic test_backpressure();
        bit          ok;
        int          d;
        logic [10:0] held_v;
        held_v = {7'b0000011, 4'd10};
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out_valid(40, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL bp_timeout: out_valid=%b want 1 within 40 cycles", out_valid);
        end
        d = cyc;
        for (int h = 0; h <= 5; h++) begin
            if (h > 0) @(negedge clk);
            compared++;
            if (obs() !== held_v) begin
                mismatched++;
                $display("FAIL bp_hold_%0d: got %b want %b", h, obs(), held_v);
            end
            tick();
            if (h == 0) in_valid = 1'b1;
            if (h == 4) out_ready = 1'b1;
        end
        @(negedge clk);
        compared++;
        if (obs() !== IDLE_V) begin
            mismatched++;
            $display("FAIL bp_release: got %b want %b", obs(), IDLE_V);
        end
        tick();
        in_valid = 1'b0;
        wait_out_valid(40, ok);
        compared++;
        if (!ok || (cyc - (d + 6)) !== 22) begin
            mismatched++;
            $display("FAIL bp_next_block: latency %0d want 22 (seen=%0b)", cyc - (d + 6), ok);
        end
        tick();
    endtask

    task automatic test_abort();
        int  t;
        int  t2;
        int  bad;
        bit  ok;
        logic [10:0] exp_v;
        bad = 0;
        tick();
        in_valid = 1'b1;
        t = cyc;
        tick();
        in_valid = 1'b0;
        while (cyc < t + 9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        exp_v = IDLE_V;
        compared++;
        if (obs() !== exp_v) begin
            mismatched++;
            $display("FAIL abort_idle: got %b want %b", obs(), exp_v);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            @(negedge clk);
            if (round_step || out_valid) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
        end
        tick();
        in_valid = 1'b1;
        t2 = cyc;
        tick();
        in_valid = 1'b0;
        wait_out_valid(40, ok);
        compared++;
        if (!ok || (cyc - t2) !== 22) begin
            mismatched++;
            $display("FAIL abort_fresh: latency %0d want 22 (seen=%0b)", cyc - t2, ok);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int t;
        tick();
        in_valid = 1'b1;
        t = cyc;
        tick();
        in_valid = 1'b0;
        while (cyc < t + 15) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (obs() !== IDLE_V) begin
            mismatched++;
            $display("FAIL reset_mid: got %b want %b", obs(), IDLE_V);
        end
        tick();
    endtask

    task automatic test_sweep();
        int first_ov;
        int lr_cnt;
        int lr_at;
        int steps;
        logic [3:0] max_idx;
        first_ov = -1;
        lr_cnt   = 0;
        lr_at    = -1;
        steps    = 0;
        max_idx  = '0;
        tick();
        in_valid2 = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready2 !== 1'b1) begin
            mismatched++;
            $display("FAIL sweep_ready: got %b want 1", in_ready2);
        end
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1) in_valid2 = 1'b0;
            @(negedge clk);
            if (out_valid2 && first_ov < 0) first_ov = k;
            if (last_round2) begin
                lr_cnt++;
                lr_at = k;
            end
            if (round_step2) steps++;
            if (round_idx2 > max_idx) max_idx = round_idx2;
        end
        compared++;
        if (first_ov !== 16) begin
            mismatched++;
            $display("FAIL sweep_latency: got T+%0d want T+16", first_ov);
        end
        compared++;
        if (lr_cnt !== 1 || lr_at !== 15) begin
            mismatched++;
            $display("FAIL sweep_last_round: got %0d cycles at T+%0d want 1 at T+15", lr_cnt, lr_at);
        end
        compared++;
        if (max_idx !== 4'd14 || steps !== 14) begin
            mismatched++;
            $display("FAIL sweep_rounds: got idx %0d steps %0d want 14 and 14", max_idx, steps);
        end
    endtask

    task automatic test_idle_abort();
        tick();
        in_valid = 1'b1;
        abort    = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (obs() !== IDLE_V) begin
                mismatched++;
                $display("FAIL idle_abort_%0d: got %b want %b", i, obs(), IDLE_V);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int acc[2];
        int n;
        bit ok;
        n = 0;
        acc[0] = 0;
        acc[1] = 0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc[n] = cyc;
                n++;
            end
            tick();
            if (n == 2) begin
                in_valid = 1'b0;
                break;
            end
        end
        compared++;
        if (n !== 2 || (acc[1] - acc[0]) !== 3 + NR * LAT) begin
            mismatched++;
            $display("FAIL b2b_gap: got %0d accepts gap %0d want 2 gap %0d", n, acc[1] - acc[0], 3 + NR * LAT);
        end
        wait_out_valid(40, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL b2b_second: out_valid=%b want 1 within 40 cycles", out_valid);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_sweep();
        test_idle_abort();
        test_back_to_back();
        @(negedge clk);
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL sb_drain: got %0d pending blocks want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
